// File: rtl/trap_handle_pkg.sv
// trap_handle_pkg: privilege levels, cause codes, interrupt priority and CSR indices
package trap_handle_pkg;
   typedef enum logic [1:0] {PRV_U = 2'd0, PRV_S = 2'd1, PRV_M = 2'd3} priv_e;
   localparam logic [5:0] CAUSE_SSI = 6'd1;
   localparam logic [5:0] CAUSE_MSI = 6'd3;
   localparam logic [5:0] CAUSE_STI = 6'd5;
   localparam logic [5:0] CAUSE_MTI = 6'd7;
   localparam logic [5:0] CAUSE_SEI = 6'd9;
   localparam logic [5:0] CAUSE_MEI = 6'd11;
   localparam int IRQ_N = 6;
   localparam logic [5:0] IRQ_PRIO [IRQ_N] = '{CAUSE_MEI, CAUSE_MSI, CAUSE_MTI, CAUSE_SEI, CAUSE_SSI, CAUSE_STI};
   localparam logic [11:0] CSR_SEPC   = 12'h141;
   localparam logic [11:0] CSR_SCAUSE = 12'h142;
   localparam logic [11:0] CSR_STVAL  = 12'h143;
   localparam logic [11:0] CSR_SIP    = 12'h144;
   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;
   localparam logic [11:0] CSR_MTVAL  = 12'h343;
   localparam logic [11:0] CSR_MIP    = 12'h344;
endpackage

// File: rtl/trap_handle_irq_sync.sv
// trap_handle_irq_sync: STAGES-deep flop chain for a vector of interrupt lines
module trap_handle_irq_sync #(
   parameter int STAGES = 2,
   parameter int W      = 4
) (
   input  logic         clk_i,
   input  logic         arst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [STAGES-1:0][W-1:0] s_q;
   // shift the line vector through the chain
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) s_q <= '0;
      else begin
         s_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) s_q[i] <= s_q[i-1];
      end
   end
   assign q_o = s_q[STAGES-1];
endmodule

// File: rtl/trap_handle.sv
// trap_handle: trap decision plus epc/cause/tval/mip state; PRV664_IRQ_SYNC_EN selects SYNC_STAGES-deep irq sync
module trap_handle
   import trap_handle_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk_i,
   input  logic            arst_i,
   input  logic            irq_mei_i,
   input  logic            irq_mti_i,
   input  logic            irq_msi_i,
   input  logic            irq_sei_i,
   input  logic [1:0]      privilege,
   input  logic            status_mie,
   input  logic            status_sie,
   input  logic [XLEN-1:0] mie,
   input  logic [XLEN-1:0] mideleg,
   input  logic [XLEN-1:0] medeleg,
   input  logic            instr_commit_valid,
   input  logic [XLEN-1:0] commit_pc,
   input  logic            commit_exc,
   input  logic [5:0]      commit_cause,
   input  logic [XLEN-1:0] commit_tval,
   input  logic            csr_commit_valid,
   input  logic            csren,
   input  logic [11:0]     csrindex,
   input  logic [XLEN-1:0] csrdata,
   output logic            trap_m,
   output logic            trap_s,
   output logic            trap_async,
   output logic [XLEN-1:0] trap_cause,
   output logic [XLEN-1:0] mepc,
   output logic [XLEN-1:0] mcause,
   output logic [XLEN-1:0] mtval,
   output logic [XLEN-1:0] sepc,
   output logic [XLEN-1:0] scause,
   output logic [XLEN-1:0] stval,
   output logic [XLEN-1:0] mip,
   output logic [XLEN-1:0] sip
);
`ifdef PRV664_IRQ_SYNC_EN
   localparam int STAGES = SYNC_STAGES;
`else
   localparam int STAGES = 1 + 0 * SYNC_STAGES;
`endif
   localparam logic [XLEN-1:0] SIP_MASK = XLEN'((1 << CAUSE_SSI) | (1 << CAUSE_STI) | (1 << CAUSE_SEI));
   logic [3:0]      irq_s;
   logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, sepc_q, scause_q, stval_q;
   logic [XLEN-1:0] mepc_d, mcause_d, mtval_d, sepc_d, scause_d, stval_d;
   logic            ssip_q, stip_q, seip_q, ssip_d, stip_d, seip_d;
   logic [XLEN-1:0] irq_en;
   logic            m_glob, s_glob, irq_hit, trap_any, to_s, csr_we;
   logic [5:0]      irq_code, code;
   logic [XLEN-1:0] epc, tval;

   trap_handle_irq_sync #(.STAGES(STAGES), .W(4)) u_irq_sync (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .d_i    ({irq_mei_i, irq_sei_i, irq_mti_i, irq_msi_i}),
      .q_o    (irq_s)
   );

   // assemble mip from synchronised lines and software-writable bits
   always_comb begin
      mip = '0;
      mip[CAUSE_MEI] = irq_s[3];
      mip[CAUSE_SEI] = irq_s[2] | seip_q;
      mip[CAUSE_MTI] = irq_s[1];
      mip[CAUSE_MSI] = irq_s[0];
      mip[CAUSE_SSI] = ssip_q;
      mip[CAUSE_STI] = stip_q;
   end
   assign sip = mip & mideleg & SIP_MASK;

   assign m_glob = (privilege != PRV_M) | status_mie;
   assign s_glob = (privilege == PRV_U) | ((privilege == PRV_S) & status_sie);
   assign irq_en = mip & mie & ((~mideleg & {XLEN{m_glob}}) | (mideleg & {XLEN{s_glob}}));

   // pick the highest-priority enabled interrupt; later iterations are higher priority
   always_comb begin
      irq_hit  = 1'b0;
      irq_code = '0;
      for (int k = IRQ_N - 1; k >= 0; k--) begin
         if (irq_en[IRQ_PRIO[k]]) begin
            irq_hit  = 1'b1;
            irq_code = IRQ_PRIO[k];
         end
      end
   end

   assign trap_any   = instr_commit_valid & (irq_hit | commit_exc);
   assign to_s       = irq_hit ? mideleg[irq_code] : (medeleg[commit_cause] & (privilege != PRV_M));
   assign code       = irq_hit ? irq_code : commit_cause;
   assign trap_m     = trap_any & ~to_s;
   assign trap_s     = trap_any & to_s;
   assign trap_async = instr_commit_valid & irq_hit;
   assign trap_cause = trap_any ? {trap_async, {(XLEN-7){1'b0}}, code} : '0;
   assign epc        = {commit_pc[XLEN-1:1], 1'b0};
   assign tval       = irq_hit ? '0 : commit_tval;
   assign csr_we     = csr_commit_valid & csren;

   // next state: CSR writes first, trap updates override them
   always_comb begin
      mepc_d   = (csr_we && csrindex == CSR_MEPC)   ? {csrdata[XLEN-1:1], 1'b0} : mepc_q;
      mcause_d = (csr_we && csrindex == CSR_MCAUSE) ? csrdata : mcause_q;
      mtval_d  = (csr_we && csrindex == CSR_MTVAL)  ? csrdata : mtval_q;
      sepc_d   = (csr_we && csrindex == CSR_SEPC)   ? {csrdata[XLEN-1:1], 1'b0} : sepc_q;
      scause_d = (csr_we && csrindex == CSR_SCAUSE) ? csrdata : scause_q;
      stval_d  = (csr_we && csrindex == CSR_STVAL)  ? csrdata : stval_q;
      ssip_d   = (csr_we && csrindex == CSR_MIP) ? csrdata[CAUSE_SSI]
               : (csr_we && csrindex == CSR_SIP && mideleg[CAUSE_SSI]) ? csrdata[CAUSE_SSI] : ssip_q;
      stip_d   = (csr_we && csrindex == CSR_MIP) ? csrdata[CAUSE_STI] : stip_q;
      seip_d   = (csr_we && csrindex == CSR_MIP) ? csrdata[CAUSE_SEI] : seip_q;
      if (trap_m) begin
         mepc_d   = epc;
         mcause_d = trap_cause;
         mtval_d  = tval;
      end
      if (trap_s) begin
         sepc_d   = epc;
         scause_d = trap_cause;
         stval_d  = tval;
      end
   end

   // trap CSR state registers
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         mepc_q   <= '0;
         mcause_q <= '0;
         mtval_q  <= '0;
         sepc_q   <= '0;
         scause_q <= '0;
         stval_q  <= '0;
         ssip_q   <= 1'b0;
         stip_q   <= 1'b0;
         seip_q   <= 1'b0;
      end else begin
         mepc_q   <= mepc_d;
         mcause_q <= mcause_d;
         mtval_q  <= mtval_d;
         sepc_q   <= sepc_d;
         scause_q <= scause_d;
         stval_q  <= stval_d;
         ssip_q   <= ssip_d;
         stip_q   <= stip_d;
         seip_q   <= seip_d;
      end
   end

   assign mepc   = mepc_q;
   assign mcause = mcause_q;
   assign mtval  = mtval_q;
   assign sepc   = sepc_q;
   assign scause = scause_q;
   assign stval  = stval_q;
endmodule

// File: tb/tb_trap_handle.sv
// tb_trap_handle: directed vectors for trap_handle; PRV664_IRQ_SYNC_EN changes expected irq latency
module tb_trap_handle;
`ifdef PRV664_IRQ_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic        clk_i = 1'b0, arst_i;
   logic        irq_mei_i, irq_mti_i, irq_msi_i, irq_sei_i;
   logic [1:0]  privilege;
   logic        status_mie, status_sie;
   logic [63:0] mie, mideleg, medeleg;
   logic        instr_commit_valid, commit_exc;
   logic [63:0] commit_pc, commit_tval;
   logic [5:0]  commit_cause;
   logic        csr_commit_valid, csren;
   logic [11:0] csrindex;
   logic [63:0] csrdata;
   logic        trap_m, trap_s, trap_async;
   logic [63:0] trap_cause, mepc, mcause, mtval, sepc, scause, stval, mip, sip;
   int          checks = 0, failures = 0;

   trap_handle dut (
      .clk_i(clk_i), .arst_i(arst_i),
      .irq_mei_i(irq_mei_i), .irq_mti_i(irq_mti_i), .irq_msi_i(irq_msi_i), .irq_sei_i(irq_sei_i),
      .privilege(privilege), .status_mie(status_mie), .status_sie(status_sie),
      .mie(mie), .mideleg(mideleg), .medeleg(medeleg),
      .instr_commit_valid(instr_commit_valid), .commit_pc(commit_pc), .commit_exc(commit_exc),
      .commit_cause(commit_cause), .commit_tval(commit_tval),
      .csr_commit_valid(csr_commit_valid), .csren(csren), .csrindex(csrindex), .csrdata(csrdata),
      .trap_m(trap_m), .trap_s(trap_s), .trap_async(trap_async), .trap_cause(trap_cause),
      .mepc(mepc), .mcause(mcause), .mtval(mtval), .sepc(sepc), .scause(scause), .stval(stval),
      .mip(mip), .sip(sip)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic csr_wr(input logic [11:0] idx, input logic [63:0] data);
      csr_commit_valid = 1'b1;
      csren = 1'b1;
      csrindex = idx;
      csrdata = data;
      tick();
      csr_commit_valid = 1'b0;
      csren = 1'b0;
   endtask

   initial begin
      arst_i = 1'b1;
      {irq_mei_i, irq_mti_i, irq_msi_i, irq_sei_i} = '0;
      privilege = 2'd3; status_mie = 0; status_sie = 0;
      mie = '0; mideleg = '0; medeleg = '0;
      instr_commit_valid = 0; commit_exc = 0; commit_pc = '0; commit_tval = '0; commit_cause = '0;
      csr_commit_valid = 0; csren = 0; csrindex = '0; csrdata = '0;
      #12;
      check_eq("rst_mepc", mepc, 64'h0);
      check_eq("rst_scause", scause, 64'h0);
      check_eq("rst_mip", mip, 64'h0);
      check_eq("rst_trap", {61'h0, trap_m, trap_s, trap_async}, 64'h0);
      arst_i = 1'b0;
      tick();
      csr_wr(12'h343, 64'h55);
      check_eq("csr_mtval", mtval, 64'h55);
      // 1: MTI taken to M
      mie = 64'h80; status_mie = 1; irq_mti_i = 1;
      repeat (LAT) tick();
      check_eq("t1_mip", mip, 64'h80);
      instr_commit_valid = 1; commit_pc = 64'h8000_0010; commit_exc = 1; commit_cause = 6'd2; commit_tval = 64'hdead;
      #1;
      check_eq("t1_trap", {61'h0, trap_m, trap_s, trap_async}, 64'h5);
      check_eq("t1_cause", trap_cause, 64'h8000_0000_0000_0007);
      tick();
      instr_commit_valid = 0;
      #1;
      check_eq("t1_mepc", mepc, 64'h8000_0010);
      check_eq("t1_mcause", mcause, 64'h8000_0000_0000_0007);
      check_eq("t1_mtval", mtval, 64'h0);
      check_eq("idle_trap", {61'h0, trap_m, trap_s, trap_async}, 64'h0);
      // 2: delegated exception from U, then same cause from M
      irq_mti_i = 0; mie = '0;
      privilege = 2'd0; medeleg = 64'h2000;
      instr_commit_valid = 1; commit_exc = 1; commit_cause = 6'd13; commit_tval = 64'h1234; commit_pc = 64'h4000_0103;
      #1;
      check_eq("t2_trap", {61'h0, trap_m, trap_s, trap_async}, 64'h2);
      check_eq("t2_cause", trap_cause, 64'd13);
      tick();
      check_eq("t2_sepc", sepc, 64'h4000_0102);
      check_eq("t2_scause", scause, 64'd13);
      check_eq("t2_stval", stval, 64'h1234);
      privilege = 2'd3; commit_pc = 64'h200;
      #1;
      check_eq("t2_m_trap", {61'h0, trap_m, trap_s, trap_async}, 64'h4);
      tick();
      instr_commit_valid = 0;
      check_eq("t2_mcause", mcause, 64'd13);
      check_eq("t2_mtval", mtval, 64'h1234);
      check_eq("t2_mepc", mepc, 64'h200);
      // 3: priority MEI > MTI > SSI
      mie = 64'h882; irq_mei_i = 1; irq_mti_i = 1;
      csr_wr(12'h344, 64'h2);
      repeat (LAT) tick();
      check_eq("t3_mip", mip, 64'h882);
      instr_commit_valid = 1; commit_exc = 1; commit_cause = 6'd2;
      #1;
      check_eq("t3_cause_mei", trap_cause, 64'h8000_0000_0000_000B);
      check_eq("t3_trap", {61'h0, trap_m, trap_s, trap_async}, 64'h5);
      instr_commit_valid = 0; irq_mei_i = 0;
      repeat (LAT) tick();
      instr_commit_valid = 1;
      #1;
      check_eq("t3_cause_mti", trap_cause, 64'h8000_0000_0000_0007);
      instr_commit_valid = 0; irq_mti_i = 0;
      repeat (LAT) tick();
      instr_commit_valid = 1;
      #1;
      check_eq("t3_cause_ssi", trap_cause, 64'h8000_0000_0000_0001);
      instr_commit_valid = 0; commit_exc = 0;
      // 4: delegated SEI masked in M, taken in S/U
      csr_wr(12'h344, 64'h0);
      mie = 64'h200; mideleg = 64'h200; irq_sei_i = 1; status_sie = 1; privilege = 2'd3;
      repeat (LAT) tick();
      check_eq("t4_mip", mip, 64'h200);
      check_eq("t4_sip", sip, 64'h200);
      instr_commit_valid = 1;
      #1;
      check_eq("t4_m_masked", {61'h0, trap_m, trap_s, trap_async}, 64'h0);
      privilege = 2'd1;
      #1;
      check_eq("t4_s_trap", {61'h0, trap_m, trap_s, trap_async}, 64'h3);
      check_eq("t4_cause", trap_cause, 64'h8000_0000_0000_0009);
      status_sie = 0;
      #1;
      check_eq("t4_sie_off", {61'h0, trap_m, trap_s, trap_async}, 64'h0);
      privilege = 2'd0;
      #1;
      check_eq("t4_u_trap", {61'h0, trap_m, trap_s, trap_async}, 64'h3);
      instr_commit_valid = 0; irq_sei_i = 0; mie = '0;
      // 5: mepc write clears bit0; trap beats same-cycle CSR write
      csr_wr(12'h341, 64'hAAAB);
      check_eq("t5_mepc_wr", mepc, 64'hAAAA);
      privilege = 2'd3; instr_commit_valid = 1; commit_exc = 1; commit_cause = 6'd2;
      commit_pc = 64'h100; commit_tval = 64'h77;
      csr_commit_valid = 1; csren = 1; csrindex = 12'h341; csrdata = 64'hAAAA;
      tick();
      instr_commit_valid = 0; commit_exc = 0; csr_commit_valid = 0; csren = 0;
      check_eq("t5_mepc", mepc, 64'h100);
      check_eq("t5_mcause", mcause, 64'd2);
      check_eq("t5_mtval", mtval, 64'h77);
      // sip writes SSIP only when delegated
      mideleg = '0;
      repeat (LAT) tick();
      csr_wr(12'h144, 64'h2);
      check_eq("sip_nodeleg", mip, 64'h0);
      mideleg = 64'h2;
      csr_wr(12'h144, 64'h2);
      check_eq("sip_deleg_mip", mip, 64'h2);
      check_eq("sip_deleg_sip", sip, 64'h2);
      csr_wr(12'h344, 64'h220);
      check_eq("mip_sw_bits", mip, 64'h220);
      csr_wr(12'h344, 64'h0);
      // 6: irq latency and async reset
      irq_msi_i = 1;
      for (int i = 0; i < LAT; i++) begin
         #1;
         check_eq("t6_lat", mip, 64'h0);
         tick();
      end
      check_eq("t6_mip", mip, 64'h8);
      #2;
      arst_i = 1'b1;
      #1;
      check_eq("t6_rst_mip", mip, 64'h0);
      check_eq("t6_rst_mepc", mepc, 64'h0);
      check_eq("t6_rst_stval", stval, 64'h0);
      arst_i = 1'b0;
      repeat (LAT) tick();
      check_eq("t6_repend", mip, 64'h8);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
